// File: rtl/iterative_alu.sv
`default_nettype none
// ============================================================================
// Module   : iterative_alu
// Purpose  : Handshaked W-bit ALU for the 3-bit opcode / 3-bit function set.
//            Shifts run one bit per cycle with a variable amount; a
//            persistent flag register feeds carries, compares, fills and
//            branch evaluation.
// Revision : 1.0  initial release
// ============================================================================
module iterative_alu #(
  parameter int W   = 8,
  parameter int SHW = $clog2(W) + 1
) (
  input  logic           CLK,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     op,
  input  logic [2:0]     fn,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [SHW-1:0] shamt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   result,
  output logic           flag,
  output logic           branch_taken
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  localparam logic [2:0] c_OP_LW    = 3'b000;
  localparam logic [2:0] c_OP_SW    = 3'b001;
  localparam logic [2:0] c_OP_ADD   = 3'b010;
  localparam logic [2:0] c_OP_SUB   = 3'b011;
  localparam logic [2:0] c_OP_CEQ   = 3'b100;
  localparam logic [2:0] c_OP_CLT   = 3'b101;
  localparam logic [2:0] c_OP_SEI   = 3'b110;

  localparam logic [2:0] c_FN_SHL_X = 3'b000;
  localparam logic [2:0] c_FN_SHL_F = 3'b001;
  localparam logic [2:0] c_FN_SHL_O = 3'b010;
  localparam logic [2:0] c_FN_SHR_X = 3'b011;
  localparam logic [2:0] c_FN_SHR_F = 3'b100;
  localparam logic [2:0] c_FN_B0    = 3'b110;
  localparam logic [2:0] c_FN_B1    = 3'b111;

  localparam logic [SHW-1:0] c_W = SHW'(W);

  logic [1:0]     state_q,  state_d;
  logic [SHW-1:0] cnt_q,    cnt_d;
  logic [W-1:0]   work_q,   work_d;
  logic           fill_q,   fill_d;
  logic           left_q,   left_d;
  logic [W-1:0]   result_q, result_d;
  logic           flag_q,   flag_d;
  logic           branch_q, branch_d;
  logic           valid_q,  valid_d;

  logic           w_accept;
  logic [W:0]     w_sum;
  logic [SHW-1:0] w_n;
  logic           w_fill;
  logic [W-1:0]   w_shifted;
  logic           w_out_bit;

  assign in_ready     = (state_q == c_IDLE) || ((state_q == c_DONE) && out_ready);
  assign w_accept     = in_valid && in_ready;
  assign out_valid    = valid_q;
  assign result       = result_q;
  assign flag         = flag_q;
  assign branch_taken = branch_q;

  // Operand-side helpers: adder with carry, clipped shift count, fill bit,
  // and the single-bit step applied to the working register.
  always_comb begin
    w_sum = {1'b0, a} + {1'b0, b};
    w_n   = (shamt >= c_W) ? c_W : shamt;
    case (fn)
      c_FN_SHL_X, c_FN_SHR_X: w_fill = 1'b0;
      c_FN_SHL_F, c_FN_SHR_F: w_fill = flag_q;
      default:                w_fill = 1'b1;
    endcase
    if (left_q) begin
      w_shifted = {work_q[W-2:0], fill_q};
      w_out_bit = work_q[W-1];
    end else begin
      w_shifted = {fill_q, work_q[W-1:1]};
      w_out_bit = work_q[0];
    end
  end

  // Next-state logic: accept/compute, iterate shifts, drain results.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    fill_d   = fill_q;
    left_d   = left_q;
    result_d = result_q;
    flag_d   = flag_q;
    branch_d = branch_q;
    valid_d  = valid_q;

    if (state_q == c_SHIFT) begin
      work_d = w_shifted;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == SHW'(1)) begin
        state_d  = c_DONE;
        result_d = w_shifted;
        flag_d   = w_out_bit;
        valid_d  = 1'b1;
      end
    end else if (w_accept) begin
      // A new op replaces any result being handed off this same cycle.
      state_d  = c_DONE;
      valid_d  = 1'b1;
      branch_d = 1'b0;
      case (op)
        c_OP_LW, c_OP_SW: result_d = w_sum[W-1:0];
        c_OP_ADD: begin
          result_d = w_sum[W-1:0];
          flag_d   = w_sum[W];
        end
        c_OP_SUB: begin
          result_d = a - b;
          flag_d   = (a < b);
        end
        c_OP_CEQ: begin
          result_d = {{(W-1){1'b0}}, (a == b)};
          flag_d   = (a == b);
        end
        c_OP_CLT: begin
          result_d = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
          flag_d   = ($signed(a) < $signed(b));
        end
        c_OP_SEI: result_d = b;
        default: begin
          result_d = a;
          if (fn == c_FN_B0) begin
            branch_d = ~flag_q;
          end else if (fn == c_FN_B1) begin
            branch_d = flag_q;
          end else if (w_n != '0) begin
            // Iterative shift: the result appears only once the count drains.
            state_d = c_SHIFT;
            valid_d = 1'b0;
            cnt_d   = w_n;
            work_d  = a;
            fill_d  = w_fill;
            left_d  = (fn < c_FN_SHR_X);
          end
        end
      endcase
    end else if ((state_q == c_DONE) && out_ready) begin
      state_d = c_IDLE;
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q  <= c_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      fill_q   <= 1'b0;
      left_q   <= 1'b0;
      result_q <= '0;
      flag_q   <= 1'b0;
      branch_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      fill_q   <= fill_d;
      left_q   <= left_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      branch_q <= branch_d;
      valid_q  <= valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iterative_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_iterative_alu
// Purpose  : Directed scoreboard bench for iterative_alu (W=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_iterative_alu;

  localparam int W   = 8;
  localparam int SHW = $clog2(W) + 1;

  localparam logic [2:0] OP_LW = 3'b000, OP_ADD = 3'b010, OP_SUB = 3'b011;
  localparam logic [2:0] OP_CEQ = 3'b100, OP_CLT = 3'b101, OP_SEI = 3'b110;
  localparam logic [2:0] OP_OTH = 3'b111;
  localparam logic [2:0] SHL_X = 3'b000, SHL_F = 3'b001, SHL_O = 3'b010;
  localparam logic [2:0] SHR_X = 3'b011, SHR_F = 3'b100, SHR_O = 3'b101;
  localparam logic [2:0] FN_B0 = 3'b110, FN_B1 = 3'b111;

  logic           CLK = 1'b0;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     op;
  logic [2:0]     fn;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [SHW-1:0] shamt;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   result;
  logic           flag;
  logic           branch_taken;

  typedef struct {
    logic [W-1:0] r;
    logic         f;
    logic         br;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  iterative_alu #(.W(W), .SHW(SHW)) dut (
    .CLK          (CLK),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op),
    .fn           (fn),
    .a            (a),
    .b            (b),
    .shamt        (shamt),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .flag         (flag),
    .branch_taken (branch_taken)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completed output handshake is compared with the oldest
  // expected response.
  always @(negedge CLK) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(result), 32'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 32'(result), 32'(e.r));
        chk("flag", 32'(flag), 32'(e.f));
        chk("branch_taken", 32'(branch_taken), 32'(e.br));
      end
    end
  end

  // Issue one op; optionally record its expectation and measure the number
  // of cycles until out_valid, checking in_ready stays low meanwhile.
  task automatic issue(input logic [2:0] o, input logic [2:0] f,
                       input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic [SHW-1:0] sa, input logic push,
                       input logic [W-1:0] er, input logic ef, input logic ebr,
                       input int lat);
    int guard;
    exp_t e;
    op = o; fn = f; a = va; b = vb; shamt = sa; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    if (!in_ready) chk("accept_timeout", 32'(guard), 32'd0);
    if (push) begin
      e.r = er; e.f = ef; e.br = ebr;
      sb.push_back(e);
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    if (lat > 0) begin
      int t;
      t = 0;
      do begin
        @(negedge CLK);
        t++;
        if (!out_valid) chk("in_ready_busy", 32'(in_ready), 32'd0);
      end while (!out_valid && t < 40);
      chk("latency", 32'(t), 32'(lat));
    end
  endtask

  initial begin
    int c0;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; fn = '0; a = '0; b = '0; shamt = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flag", 32'(flag), 32'd0);
    chk("rst_branch", 32'(branch_taken), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    @(posedge CLK);
    #1;

    issue(OP_ADD, 3'b000, 8'hF0, 8'h20, 4'd0, 1'b1, 8'h10, 1'b1, 1'b0, 1);
    issue(OP_OTH, SHL_O,  8'h81, 8'h00, 4'd3, 1'b1, 8'h0F, 1'b0, 1'b0, 4);
    issue(OP_CEQ, 3'b000, 8'h55, 8'h55, 4'd7, 1'b1, 8'h01, 1'b1, 1'b0, 1);
    issue(OP_OTH, SHR_F,  8'h02, 8'h00, 4'd2, 1'b1, 8'hC0, 1'b1, 1'b0, 3);
    issue(OP_OTH, FN_B1,  8'h3C, 8'h99, 4'd5, 1'b1, 8'h3C, 1'b1, 1'b1, 1);
    issue(OP_OTH, FN_B0,  8'hA5, 8'h00, 4'd0, 1'b1, 8'hA5, 1'b1, 1'b0, 1);
    issue(OP_OTH, SHL_X,  8'hFF, 8'h00, 4'd12, 1'b1, 8'h00, 1'b1, 1'b0, 9);

    // Back-to-back non-shift ops: one accepted every cycle.
    c0 = cyc;
    issue(OP_SEI, 3'b000, 8'h00, 8'h77, 4'd3, 1'b1, 8'h77, 1'b1, 1'b0, 0);
    issue(OP_CLT, 3'b000, 8'h01, 8'h80, 4'd0, 1'b1, 8'h00, 1'b0, 1'b0, 0);
    issue(OP_LW,  3'b000, 8'h10, 8'h05, 4'd0, 1'b1, 8'h15, 1'b0, 1'b0, 0);
    issue(OP_CLT, 3'b000, 8'h80, 8'h01, 4'd0, 1'b1, 8'h01, 1'b1, 1'b0, 0);
    chk("throughput_cycles", 32'(cyc - c0), 32'd4);
    @(negedge CLK);

    issue(OP_OTH, SHR_X,  8'h5A, 8'h00, 4'd0, 1'b1, 8'h5A, 1'b1, 1'b0, 1);
    issue(OP_OTH, SHR_O,  8'h25, 8'h00, 4'd8, 1'b1, 8'hFF, 1'b0, 1'b0, 9);
    issue(OP_OTH, SHL_F,  8'hC3, 8'h00, 4'd1, 1'b1, 8'h86, 1'b1, 1'b0, 2);

    // Backpressure: result held while the consumer stalls.
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
    issue(OP_ADD, 3'b000, 8'h7F, 8'h01, 4'd0, 1'b1, 8'h80, 1'b0, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_result", 32'(result), 32'h80);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
    c0 = cyc;
    issue(OP_SUB, 3'b000, 8'h03, 8'h05, 4'd0, 1'b1, 8'hFE, 1'b1, 1'b0, 1);
    chk("bp_same_cycle_accept", 32'(cyc - c0), 32'd1);

    // Reset on the third SHIFT cycle discards the shift.
    @(posedge CLK);
    #1;
    issue(OP_OTH, SHL_X, 8'hFF, 8'h00, 4'd6, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    chk("mid_shift_busy", 32'(in_ready), 32'd0);
    reset_n = 1'b0;
    @(posedge CLK);
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_result", 32'(result), 32'd0);
    chk("mrst_flag", 32'(flag), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    issue(OP_ADD, 3'b000, 8'h12, 8'h34, 4'd0, 1'b1, 8'h46, 1'b0, 1'b0, 1);

    repeat (3) @(posedge CLK);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("final_out_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/iterative_alu.md
Name: iterative_alu

Overview:
- Parametrised, handshaked ALU that executes the 3-bit opcode / 3-bit function instruction set.
- Generalises data width to W and executes the six shift functions iteratively, one bit per cycle, with variable shift amounts.
- Adds a persistent flag register, valid/ready handshakes on both sides, and branch-condition evaluation.
- Sits between the decode stage and register-file writeback.

Parameters:
- W, 8, data width in bits (W >= 4).
- SHW, $clog2(W)+1, width of the shift-amount field; wide enough to encode W.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  synchronous reset, active low.
- in_valid  input  1  operation request valid.
- in_ready  output  1  ALU can accept an operation this cycle.
- op  input  3  opcode: LW=000, SW=001, ADD=010, SUB=011, CEQ=100, CLT=101, SEI=110, OTHER=111.
- fn  input  3  function code, used only when op=OTHER: SHIFTL_X=000, SHIFTL_F=001, SHIFTL_O=010, SHIFTR_X=011, SHIFTR_F=100, SHIFTR_O=101, B0=110, B1=111.
- a  input  W  operand A; the shift source for shifts.
- b  input  W  operand B.
- shamt  input  SHW  shift amount, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  W  registered result.
- flag  output  1  current flag register.
- branch_taken  output  1  branch condition for the B0/B1 result; 0 for all other ops.

Behaviour:
- Reset: when reset_n=0 at a clock edge, the following apply regardless of state, including mid-shift; any in-flight operation is discarded.
  - state=IDLE; out_valid=0; result=0; flag=0; branch_taken=0.
- FSM states: IDLE, SHIFT, DONE.
- Readiness: in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept: an operation is accepted when in_valid && in_ready.
- Operand capture on accept: op, fn, a, b, n = min(shamt, W), and fill bit.
  - _X fill bit = 0.
  - _F fill bit = flag value at accept.
  - _O fill bit = 1.
- Non-shift ops, and shifts with n=0: computed at accept, registered, state->DONE. out_valid rises 1 cycle after accept.
- Shifts with n>0: state->SHIFT with counter=n.
  - Each SHIFT cycle shifts the working register by one bit and inserts the fill bit (L: at LSB, shifting out the MSB; R: at MSB, shifting out the LSB).
  - Each SHIFT cycle decrements the counter.
  - When the counter reaches 0, state->DONE.
  - out_valid rises n+1 cycles after accept.
- Shift amount clipping: shamt >= W behaves exactly as W, so the result is all fill bits after W iterations.
- Op semantics (W-bit, modulo 2^W):
  - LW/SW: result = a+b (address); flag unchanged.
  - ADD: result = a+b; flag = carry-out.
  - SUB: result = a-b; flag = borrow, i.e. a<b unsigned.
  - CEQ: result = zero-extended (a==b); flag = (a==b).
  - CLT: signed compare; result = zero-extended (a<b); flag = (a<b).
  - SEI: result = b; flag unchanged.
  - Shifts: result = working register. Flag = last bit shifted out if n>0; unchanged if n=0.
  - B0/B1: result = a; flag unchanged; branch_taken = (flag==0) for B0, (flag==1) for B1, evaluated with the flag at accept.
- Flag update timing: the flag register updates on the edge on which the op enters DONE.
- DONE: result, branch_taken and out_valid are held stable while out_ready=0.
  - On out_valid && out_ready: if a new op is accepted in the same cycle, proceed per that op (back-to-back, no bubble); otherwise state->IDLE and out_valid=0.
- Unused inputs: in_valid is ignored while in SHIFT. shamt is ignored for non-shift ops.
- Sustained throughput: 1 op/cycle for non-shift ops when out_ready is held high.

Test Plan:
- ADD with W=8, a=8'hF0, b=8'h20, out_ready=1 -> out_valid exactly 1 cycle after accept; result=8'h10; flag=1.
- SHIFTL_O, a=8'h81, shamt=3 -> in_ready=0 for 3 SHIFT cycles; out_valid 4 cycles after accept; result=8'h0F; flag=0.
- CEQ a=b=8'h55 (flag->1), then SHIFTR_F a=8'h02, shamt=2 -> result=8'hC0, flag=1; then B1 -> result=a, branch_taken=1; then B0 -> branch_taken=0.
- SHIFTL_X, a=8'hFF, shamt=12 -> clipped to 8 iterations; out_valid 9 cycles after accept; result=8'h00; flag=1.
- Backpressure: out_ready=0 for 5 cycles -> result and out_valid stable, in_ready=0. Then raise out_ready with in_valid=1, SUB a=8'h03, b=8'h05 -> accepted in the same cycle; next cycle result=8'hFE, flag=1.
- Reset mid-SHIFT (shamt=6, reset_n=0 on the 3rd SHIFT cycle) -> on that edge out_valid=0, result=0, flag=0, in_ready=1; a following ADD completes normally.
